// File: rtl/core_result_uart_pkg.sv
// core_result_uart_pkg
// Shared definitions for the result UART: state encodings for the frame
// sequencer and the bit serializer, plus the frame header and length.
// No ports.

package core_result_uart_pkg;

   // Serializer states; LOAD is the sequencer's pop step and is kept in this
   // enum so that the whole transmit flow shares one encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   // Frame sequencer states (parent side of IDLE/LOAD/START..STOP).
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LOAD = 2'd1,
      SEQ_SEND = 2'd2
   } seq_t;

   localparam logic [7:0] FRAME_HEADER = 8'hA0;
   localparam int         FRAME_LEN    = 5;

   function automatic logic [7:0] header_byte(input logic [1:0] channel);
      return FRAME_HEADER | {6'd0, channel};
   endfunction

endpackage

// File: rtl/core_result_uart_tx.sv
// uart_tx_byte
// 8N1 bit serializer: one start bit, 8 data bits LSB first, one stop bit,
// each CLKS_PER_BIT clocks long. A start request on the last stop-bit cycle
// chains straight into the next start bit, so bytes go out back-to-back.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   byte_in       byte to send, captured when start is accepted
//   start         request; accepted in IDLE or on the cycle done is high
//   tx            registered serial output, idle high
//   done          high on the final cycle of the stop bit
//
// state | meaning
// IDLE  | line idle high, waiting for start
// START | start bit (tx=0)
// DATA  | data bits, LSB first
// STOP  | stop bit (tx=1); done on its last cycle

module uart_tx_byte
   import core_result_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       start,
   output logic       tx,
   output logic       done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic [7:0]       shreg_next;
   logic             tx_next;
   logic             tx_r;
   logic             bit_end;
   logic             accept;

   assign bit_end = (bit_cnt == LAST_CNT);
   assign done    = (state == STOP) && bit_end;
   assign accept  = start && ((state == IDLE) || done);
   assign tx      = tx_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
         STOP:    if (bit_end) state_next = start ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // tx is registered from the next state so the line never glitches.
   always_comb begin
      shreg_next = shreg;
      if (accept) begin
         shreg_next = byte_in;
      end else if ((state == DATA) && bit_end) begin
         shreg_next = {1'b0, shreg[7:1]};
      end
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shreg_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_r    <= 1'b1;
      end else begin
         shreg <= shreg_next;
         tx_r  <= tx_next;
         if ((state == IDLE) || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (state == START) begin
            bit_idx <= '0;
         end else if ((state == DATA) && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

endmodule

// File: rtl/core_result_uart.sv
// core_result_uart
// Queues {channel, data} result words from the core in a small FIFO and
// sends each one as a 5-byte UART frame: header (A0|channel) then the data
// word MSB byte first. Words arriving with the FIFO full are dropped and
// counted; the core never sees backpressure.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   in_channel      2-bit channel tag of the pushed word
//   in_data         result word
//   in_valid        one-cycle push strobe
//   overflow_clear  clears the sticky overflow flag
//   tx              UART 8N1 output, idle high
//   busy            frame in flight or words queued
//   fifo_count      FIFO occupancy, 0..FIFO_DEPTH
//   overflow        sticky drop flag
//   dropped_count   saturating drop counter
//
// state    | meaning
// SEQ_IDLE | nothing in flight; move to LOAD when the FIFO holds a word
// SEQ_LOAD | pop head, start the header byte
// SEQ_SEND | serializer running; chain bytes 1..4, back to IDLE after last

module core_result_uart
   import core_result_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    in_channel,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   input  logic                          overflow_clear,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [15:0]                   dropped_count
);

   localparam int               PTR_W      = $clog2(FIFO_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam int               WORD_W     = DATA_WIDTH + 2;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       LAST_IDX   = 3'(FRAME_LEN - 1);

   logic [WORD_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [WORD_W-1:0]     head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  drop;

   seq_t                  seq_state;
   seq_t                  seq_next;
   logic [DATA_WIDTH-1:0] frame_data;
   logic [2:0]            byte_idx;
   logic [2:0]            next_idx;
   logic                  byte_start;
   logic                  byte_done;
   logic [7:0]            byte_in;

   assign fifo_full  = (count == FULL_COUNT);
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign drop       = in_valid && fifo_full && !pop;
   assign push       = in_valid && !drop;
   assign next_idx   = byte_idx + 3'd1;

   assign fifo_count = count;
   assign busy       = (seq_state != SEQ_IDLE) | (count != '0);

   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem[wr_ptr] <= {in_channel, in_data};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow      <= 1'b0;
         dropped_count <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
         end else if (overflow_clear) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         seq_state <= SEQ_IDLE;
      end else begin
         seq_state <= seq_next;
      end
   end

   always_comb begin
      seq_next = seq_state;
      case (seq_state)
         SEQ_IDLE: if (!fifo_empty) seq_next = SEQ_LOAD;
         SEQ_LOAD: seq_next = SEQ_SEND;
         SEQ_SEND: if (byte_done && (byte_idx == LAST_IDX)) seq_next = SEQ_IDLE;
         default:  seq_next = SEQ_IDLE;
      endcase
   end

   // The header goes straight from the FIFO head so the start bit begins on
   // the pop edge; later bytes come from the captured frame word.
   always_comb begin
      pop        = 1'b0;
      byte_start = 1'b0;
      byte_in    = header_byte(head[WORD_W-1 -: 2]);
      case (seq_state)
         SEQ_LOAD: begin
            pop        = 1'b1;
            byte_start = 1'b1;
         end
         SEQ_SEND: begin
            if (byte_done && (byte_idx != LAST_IDX)) begin
               byte_start = 1'b1;
               case (next_idx)
                  3'd1:    byte_in = frame_data[31:24];
                  3'd2:    byte_in = frame_data[23:16];
                  3'd3:    byte_in = frame_data[15:8];
                  default: byte_in = frame_data[7:0];
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_data <= '0;
         byte_idx   <= '0;
      end else if (pop) begin
         frame_data <= head[DATA_WIDTH-1:0];
         byte_idx   <= '0;
      end else if (byte_start) begin
         byte_idx <= next_idx;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clock   (clock),
      .reset   (reset),
      .byte_in (byte_in),
      .start   (byte_start),
      .tx      (tx),
      .done    (byte_done)
   );

endmodule

// File: tb/tb_core_result_uart.sv
module tb_core_result_uart;

   localparam int CPB       = 4;
   localparam int DEPTH     = 4;
   localparam int DW        = 32;
   localparam int BIT_CYC   = 10 * CPB;
   localparam int FRAME_CYC = 5 * BIT_CYC;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    in_channel;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          overflow_clear;
   logic          tx;
   logic          busy;
   logic [2:0]    fifo_count;
   logic          overflow;
   logic [15:0]   dropped_count;

   always #5 clock = ~clock;

   core_result_uart #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .DATA_WIDTH   (DW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_channel     (in_channel),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .overflow_clear (overflow_clear),
      .tx             (tx),
      .busy           (busy),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .dropped_count  (dropped_count)
   );

   // Reference model: queue of words plus a timeline of when the transmitter
   // picks up the next word and which frame is on the line.
   logic [33:0] q[$];
   int          edge_num   = 0;
   int          idle_after = 0;
   bit          load_pend  = 0;
   int          load_at    = 0;
   bit          cur_valid  = 0;
   int          cur_start  = 0;
   logic [33:0] cur_word   = '0;
   bit          m_ovf      = 0;
   int          m_drp      = 0;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_num);
      end
   endtask

   function automatic logic exp_tx();
      int         o;
      int         b;
      int         k;
      logic [7:0] by;
      if (!cur_valid || (edge_num - cur_start) >= FRAME_CYC) return 1'b1;
      o = edge_num - cur_start;
      b = o / BIT_CYC;
      k = (o % BIT_CYC) / CPB;
      if (b == 0) by = 8'hA0 | {6'd0, cur_word[33:32]};
      else        by = 8'(cur_word[31:0] >> (8 * (4 - b)));
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return by[k-1];
   endfunction

   task automatic step(input bit rst, input bit iv, input logic [1:0] ch,
                       input logic [31:0] d, input bit clr);
      bit full;
      bit pop;
      bit dropped;
      reset          = rst;
      in_valid       = iv;
      in_channel     = ch;
      in_data        = d;
      overflow_clear = clr;
      @(posedge clock);
      #1;
      edge_num++;
      if (rst) begin
         q.delete();
         idle_after = edge_num;
         load_pend  = 0;
         cur_valid  = 0;
         m_ovf      = 0;
         m_drp      = 0;
      end else begin
         full    = (q.size() == DEPTH);
         pop     = load_pend && (load_at == edge_num);
         dropped = 0;
         if (pop) begin
            cur_word   = q.pop_front();
            cur_start  = edge_num;
            cur_valid  = 1;
            idle_after = edge_num + FRAME_CYC;
            load_pend  = 0;
         end
         if (iv) begin
            if (!full || pop) begin
               q.push_back({ch, d});
            end else begin
               dropped = 1;
               m_ovf   = 1;
               if (m_drp < 65535) m_drp++;
            end
         end
         if (clr && !dropped) m_ovf = 0;
         if (!load_pend && edge_num >= idle_after && q.size() != 0) begin
            load_pend = 1;
            load_at   = edge_num + 2;
         end
      end
      check("tx", tx, exp_tx());
      check("fifo_count", fifo_count, q.size());
      check("busy", busy, (q.size() != 0) || (edge_num < idle_after));
      check("overflow", overflow, m_ovf);
      check("dropped_count", dropped_count, m_drp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0, 0);
   endtask

   initial begin
      int p;
      reset          = 1'b1;
      in_valid       = 1'b0;
      in_channel     = '0;
      in_data        = '0;
      overflow_clear = 1'b0;

      repeat (3) step(1, 0, 2'd0, 32'd0, 0);
      check("reset_tx", tx, 1);
      check("reset_count", fifo_count, 0);

      // Single frame, ch=1, 0x12345678.
      step(0, 1, 2'd1, 32'h12345678, 0);
      step(0, 0, 2'd0, 32'd0, 0);
      check("latency_hi", tx, 1);
      step(0, 0, 2'd0, 32'd0, 0);
      check("latency_lo", tx, 0);
      idle(FRAME_CYC + 10);
      check("single_busy", busy, 0);

      // Six back-to-back pushes: five accepted, one dropped.
      for (int i = 0; i < 6; i++) step(0, 1, i[1:0], $urandom, 0);
      check("six_ovf", overflow, 1);
      check("six_drop", dropped_count, 1);
      check("six_count", fifo_count, 4);
      idle(5 * (FRAME_CYC + 2) + 20);

      // Hold the FIFO full across several pops; clear overflow mid-way.
      for (int i = 0; i < 700; i++) step(0, 1, 2'($urandom), $urandom, i == 350);
      check("hold_ovf", overflow, 1);
      check("hold_drops_300", dropped_count >= 16'd300, 1);
      step(0, 0, 2'd0, 32'd0, 1);
      check("clear_ovf", overflow, 0);
      idle(4 * (FRAME_CYC + 2) + 20);

      // Reset during the third byte with two words queued.
      for (int i = 0; i < 3; i++) step(0, 1, 2'($urandom), $urandom, 0);
      idle(90);
      check("mid_count", fifo_count, 2);
      step(1, 0, 2'd0, 32'd0, 0);
      check("rst_tx", tx, 1);
      check("rst_count", fifo_count, 0);
      step(1, 1, 2'd2, 32'hDEADBEEF, 0);
      idle(FRAME_CYC * 2);

      // Randomized traffic with varying push density, clears and rare resets.
      p = 30;
      for (int i = 0; i < 8000; i++) begin
         if (i % 500 == 0) begin
            case ($urandom_range(2))
               0:       p = 5;
               1:       p = 30;
               default: p = 90;
            endcase
         end
         step($urandom_range(2999) == 0,
              $urandom_range(99) < p,
              2'($urandom),
              $urandom,
              $urandom_range(49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
